cgra_pe_v2: RTL
===============

# cgra_pe_v2

Parametrised second-generation CGRA processing element. Holds a per-PE context memory of CONTEXT_DEPTH instructions and steps through a runtime-selectable number of contexts, each for SWITCH_CYCLES clocks. Each context performs one ALU, constant, route, load or store operation on neighbour-PE inputs. It sits in the PE array between the neighbour interconnect and a per-PE memory port. Memory uses a req/ready handshake that stalls the context sequencer.

## Interface
- DATA_WIDTH, 32, datapath width
- ADDRESS_WIDTH, 16, memory address width (≤ DATA_WIDTH)
- NEIGHBOR_NUM, 4, number of neighbour inputs
- CONTEXT_DEPTH, 16, context memory entries
- SWITCH_CYCLES, 4, clocks per context window (≥ 2)
- Derived: NSEL_W = max(1, clog2(NEIGHBOR_NUM+1)); CIDX_W = max(1, clog2(CONTEXT_DEPTH))

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- cfg_write  in  1  write cfg_* fields into entry cfg_index
- cfg_index  in  CIDX_W  context entry to write
- cfg_src1, cfg_src2  in  NSEL_W  operand selects
- cfg_op  in  4  opcode
- cfg_const  in  DATA_WIDTH  constant field
- num_contexts  in  CIDX_W+1  active contexts; must stay static while run_enable=1
- run_enable  in  1  execute when high
- ctx_restart  in  1  synchronous restart to context 0
- pe_in  in  NEIGHBOR_NUM*DATA_WIDTH  flattened neighbour data; slice k = [k*DATA_WIDTH +: DATA_WIDTH]
- pe_out  out  DATA_WIDTH  registered result
- ctx_index  out  CIDX_W  current context
- iter_done  out  1  one-cycle pulse on wrap from last context to 0
- stall  out  1  sequencer frozen waiting for memory
- mem_req, mem_we  out  1  request / write qualifier
- mem_addr  out  ADDRESS_WIDTH
- mem_wdata  out  DATA_WIDTH
- mem_ready  in  1  request accepted/completed this cycle
- mem_rdata  in  DATA_WIDTH  valid when mem_req & mem_ready & !mem_we

## Operation
- Reset: all outputs 0. Context memory cleared to NOP. Window counter 0.
- Operand selection: an operand select value k < NEIGHBOR_NUM reads slice k. Any other value reads 0.
- Opcodes (A = src1, B = src2, C = const; results truncated to DATA_WIDTH):
  - 0 NOP (pe_out holds)
  - 1 A+B, 2 A−B, 3 A*B (low bits)
  - 4 unsigned A/B, with B=0 giving all-ones
  - 5 C
  - 6 LOAD from address A[ADDRESS_WIDTH-1:0]
  - 7 STORE B to address A (pe_out holds)
  - 8 ROUTE A
  - 9 A&B, 10 A|B, 11 A^B
  - 12 A<<B[clog2(DATA_WIDTH)-1:0], 13 logical A>> by the same shift amount
  - 14 unsigned A<B → 1 else 0
  - 15 A+C
- Effective context count N: N = 1 if num_contexts = 0; N = CONTEXT_DEPTH if num_contexts > CONTEXT_DEPTH; otherwise N = num_contexts.
- State machine:
  - IDLE: run_enable=0; counter and ctx_index hold.
  - ISSUE: window cycle 0. The op in entry ctx_index executes.
  - MEM: a load/store is outstanding.
  - WAIT: the remaining window cycles.
- The counter increments each cycle in ISSUE/MEM/WAIT. At SWITCH_CYCLES-1 it wraps to 0 and ctx_index advances. When ctx_index is N-1 it wraps to 0 and iter_done pulses.
- Memory handshake:
  - mem_req, mem_addr, mem_we and mem_wdata are registered from the issue cycle and stay stable until the cycle where mem_req & mem_ready.
  - mem_req drops in the cycle after that completion.
  - On a load, pe_out takes mem_rdata in the cycle after completion.
- Stall: when the counter is at SWITCH_CYCLES-1 and the transaction has not completed (no ready this cycle), the counter holds and stall=1. Advance occurs in the completion cycle.
- cfg_write priority: the write happens and, that cycle, the counter freezes and no op issues. An outstanding memory transaction continues.
- ctx_restart: ctx_index and counter go to 0 and mem_req drops next cycle. A transaction completes only on a req & ready cycle, so dropping req abandons it safely. Restart takes priority over cfg_write freeze and stall.
- run_enable falling: the sequencer freezes after any in-flight memory transaction completes. pe_out holds.

## Timing
- ALU/const/route result: issue at window cycle t, pe_out valid at t+1 and held until the next issuing op.
- Load with zero-wait memory (ready=1): mem_req is high at t+1 and pe_out = mem_rdata at t+2. No stall for SWITCH_CYCLES ≥ 2.
- Each wait cycle of ready beyond window cycle SWITCH_CYCLES-1 extends the window by one cycle.
- iter_done is high during the first cycle of context 0 following a wrap.
- Reset deassertion: the first issue happens on the first clk edge with run_enable=1.

## Test plan
- Config: write entry 0 = ADD(src 0, src 1) and entry 1 = CONST 0x55; N=2; pe_in0=3, pe_in1=4; run. Required: pe_out=7 one cycle after issue; 0x55 SWITCH_CYCLES later; iter_done pulses every 2*SWITCH_CYCLES.
- Load: entry 0 = LOAD(src 0), pe_in0=0x10, mem_ready low for 5 cycles. Required: mem_addr=0x10 stable; stall asserted for 5-(SWITCH_CYCLES-2) cycles; pe_out = mem_rdata one cycle after ready.
- Store: entry 0 = STORE with A=0x20, B=0xABCD, ready=1. Required: one cycle with mem_req=1, mem_we=1, mem_wdata=0xABCD; pe_out unchanged.
- Edge arithmetic: DIV by 0 gives 0xFFFFFFFF; SHL 1 by 33 gives 2; LT(5,3) gives 0; an out-of-range operand select reads 0.
- Restart mid-load: assert ctx_restart while mem_req is pending. Required: ctx_index=0 and counter=0 next cycle, mem_req=0, stall=0.
- Async reset mid-run: assert reset_n=0 between clock edges. Required: all outputs 0 immediately; after release, entries read as NOP and pe_out stays 0.

Source files
------------

// File: rtl/cgra_pe_v2_if.sv
// Per-PE memory port: request/ready handshake between the PE (master) and its memory (slave).
interface cgra_pe_v2_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 16
) ();
  logic                     mem_req;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     mem_ready;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/cgra_pe_v2.sv
// CGRA processing element: context memory, windowed context sequencer, ALU and stalling memory port.
module cgra_pe_v2 #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned NEIGHBOR_NUM  = 4,
  parameter int unsigned CONTEXT_DEPTH = 16,
  parameter int unsigned SWITCH_CYCLES = 4,
  localparam int unsigned NSEL_W = ($clog2(NEIGHBOR_NUM + 1) > 1) ? $clog2(NEIGHBOR_NUM + 1) : 1,
  localparam int unsigned CIDX_W = ($clog2(CONTEXT_DEPTH) > 1) ? $clog2(CONTEXT_DEPTH) : 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               cfg_write,
  input  logic [CIDX_W-1:0]                  cfg_index,
  input  logic [NSEL_W-1:0]                  cfg_src1,
  input  logic [NSEL_W-1:0]                  cfg_src2,
  input  logic [3:0]                         cfg_op,
  input  logic [DATA_WIDTH-1:0]              cfg_const,
  input  logic [CIDX_W:0]                    num_contexts,
  input  logic                               run_enable,
  input  logic                               ctx_restart,
  input  logic [NEIGHBOR_NUM*DATA_WIDTH-1:0] pe_in,
  output logic [DATA_WIDTH-1:0]              pe_out,
  output logic [CIDX_W-1:0]                  ctx_index,
  output logic                               iter_done,
  output logic                               stall,
  cgra_pe_v2_if.master                       mem
);

  localparam int unsigned CNT_W = ($clog2(SWITCH_CYCLES) > 1) ? $clog2(SWITCH_CYCLES) : 1;
  localparam int unsigned SH_W  = ($clog2(DATA_WIDTH) > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SWITCH_CYCLES - 1);
  localparam logic [CIDX_W:0]  DEPTH_C  = (CIDX_W + 1)'(CONTEXT_DEPTH);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_DIV   = 4'd4;
  localparam logic [3:0] OP_CONST = 4'd5;
  localparam logic [3:0] OP_LOAD  = 4'd6;
  localparam logic [3:0] OP_STORE = 4'd7;
  localparam logic [3:0] OP_ROUTE = 4'd8;
  localparam logic [3:0] OP_AND   = 4'd9;
  localparam logic [3:0] OP_OR    = 4'd10;
  localparam logic [3:0] OP_XOR   = 4'd11;
  localparam logic [3:0] OP_SHL   = 4'd12;
  localparam logic [3:0] OP_SHR   = 4'd13;
  localparam logic [3:0] OP_LT    = 4'd14;
  localparam logic [3:0] OP_ADDC  = 4'd15;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_MEM, ST_WAIT} state_e;

  typedef struct packed {
    logic [3:0]            op;
    logic [NSEL_W-1:0]     src1;
    logic [NSEL_W-1:0]     src2;
    logic [DATA_WIDTH-1:0] cval;
  } ctx_t;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CIDX_W-1:0]        ctx_q, ctx_d;
  logic [DATA_WIDTH-1:0]    pe_out_q, pe_out_d;
  logic                     iter_q, iter_d;
  logic                     req_q, req_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  ctx_t                     ctx_mem_q [CONTEXT_DEPTH];
  ctx_t                     ctx_mem_d [CONTEXT_DEPTH];

  ctx_t                     entry;
  logic [DATA_WIDTH-1:0]    op_a, op_b, alu;
  logic [SH_W-1:0]          shamt;
  logic [CIDX_W:0]          n_eff, last_ctx;
  logic                     pending, done, stall_c;

  // Effective context count, clamped to [1, CONTEXT_DEPTH]
  always_comb begin
    if (num_contexts == '0) n_eff = (CIDX_W + 1)'(1);
    else if (num_contexts > DEPTH_C) n_eff = DEPTH_C;
    else n_eff = num_contexts;
    last_ctx = n_eff - (CIDX_W + 1)'(1);
  end

  // Operand selection from neighbour slices; out-of-range selects read zero
  always_comb begin
    entry = ctx_mem_q[ctx_q];
    op_a  = '0;
    op_b  = '0;
    for (int unsigned k = 0; k < NEIGHBOR_NUM; k++) begin
      if (entry.src1 == NSEL_W'(k)) op_a = pe_in[k*DATA_WIDTH +: DATA_WIDTH];
      if (entry.src2 == NSEL_W'(k)) op_b = pe_in[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Datapath result for the register-writing opcodes
  always_comb begin
    shamt = op_b[SH_W-1:0];
    case (entry.op)
      OP_ADD:   alu = op_a + op_b;
      OP_SUB:   alu = op_a - op_b;
      OP_MUL:   alu = op_a * op_b;
      OP_DIV:   alu = (op_b == '0) ? '1 : op_a / op_b;
      OP_CONST: alu = entry.cval;
      OP_ROUTE: alu = op_a;
      OP_AND:   alu = op_a & op_b;
      OP_OR:    alu = op_a | op_b;
      OP_XOR:   alu = op_a ^ op_b;
      OP_SHL:   alu = op_a << shamt;
      OP_SHR:   alu = op_a >> shamt;
      OP_LT:    alu = DATA_WIDTH'(op_a < op_b);
      OP_ADDC:  alu = op_a + entry.cval;
      default:  alu = '0;
    endcase
  end

  // Sequencer, issue, memory handshake and configuration writes
  always_comb begin
    cnt_d     = cnt_q;
    ctx_d     = ctx_q;
    pe_out_d  = pe_out_q;
    iter_d    = 1'b0;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ctx_mem_d = ctx_mem_q;
    stall_c   = 1'b0;
    state_d   = state_q;
    pending   = (state_q == ST_MEM);
    done      = pending && mem.mem_ready;

    if (done) begin
      req_d = 1'b0;
      we_d  = 1'b0;
      if (!we_q) pe_out_d = mem.mem_rdata;
    end

    if (cfg_write) begin
      ctx_mem_d[cfg_index] = '{op: cfg_op, src1: cfg_src1, src2: cfg_src2, cval: cfg_const};
    end

    if (ctx_restart) begin
      // Dropping req abandons any outstanding transaction
      cnt_d = '0;
      ctx_d = '0;
      req_d = 1'b0;
      we_d  = 1'b0;
    end else if (!cfg_write && (run_enable || pending)) begin
      if (cnt_q == CNT_LAST) begin
        if (pending && !mem.mem_ready) begin
          stall_c = 1'b1;
        end else begin
          cnt_d = '0;
          if ({1'b0, ctx_q} >= last_ctx) begin
            ctx_d  = '0;
            iter_d = 1'b1;
          end else begin
            ctx_d = ctx_q + CIDX_W'(1);
          end
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      if (cnt_q == '0 && run_enable) begin
        case (entry.op)
          OP_NOP: ;
          OP_LOAD: begin
            req_d  = 1'b1;
            we_d   = 1'b0;
            addr_d = op_a[ADDRESS_WIDTH-1:0];
          end
          OP_STORE: begin
            req_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = op_a[ADDRESS_WIDTH-1:0];
            wdata_d = op_b;
          end
          default: pe_out_d = alu;
        endcase
      end
    end

    if (req_d) state_d = ST_MEM;
    else if (!run_enable) state_d = ST_IDLE;
    else if (cnt_d == '0) state_d = ST_ISSUE;
    else state_d = ST_WAIT;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ctx_q     <= '0;
      pe_out_q  <= '0;
      iter_q    <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ctx_mem_q <= '{default: '0};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctx_q     <= ctx_d;
      pe_out_q  <= pe_out_d;
      iter_q    <= iter_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ctx_mem_q <= ctx_mem_d;
    end
  end

  assign pe_out        = pe_out_q;
  assign ctx_index     = ctx_q;
  assign iter_done     = iter_q;
  assign stall         = stall_c;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule
